// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, arbiter FSM encoding and requester IDs.
package alu_pkg;

  localparam int unsigned FUN_WIDTH = 4;

  localparam logic [FUN_WIDTH-1:0] FUN_ADD = 4'h0;
  localparam logic [FUN_WIDTH-1:0] FUN_SUB = 4'h1;
  localparam logic [FUN_WIDTH-1:0] FUN_SLL = 4'h2;
  localparam logic [FUN_WIDTH-1:0] FUN_SRL = 4'h3;
  localparam logic [FUN_WIDTH-1:0] FUN_AND = 4'h4;
  localparam logic [FUN_WIDTH-1:0] FUN_OR  = 4'h5;
  localparam logic [FUN_WIDTH-1:0] FUN_XOR = 4'h6;
  localparam logic [FUN_WIDTH-1:0] FUN_SLT = 4'h7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; the requester not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters: round-robin grant,
// latch/issue/capture sequencing and a valid/ready response channel.
module alu_req_arbiter #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned FUN_WIDTH = alu_pkg::FUN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [IN_WIDTH-1:0]  req0_in1,
  input  logic [IN_WIDTH-1:0]  req0_in2,
  input  logic [FUN_WIDTH-1:0] req0_fun,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [IN_WIDTH-1:0]  req1_in1,
  input  logic [IN_WIDTH-1:0]  req1_in2,
  input  logic [FUN_WIDTH-1:0] req1_fun,
  output logic [IN_WIDTH-1:0]  alu_in1,
  output logic [IN_WIDTH-1:0]  alu_in2,
  output logic [FUN_WIDTH-1:0] alu_fun,
  output logic                 alu_en,
  input  logic [OUT_WIDTH-1:0] alu_out,
  input  logic                 alu_flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [OUT_WIDTH-1:0] rsp_out,
  output logic                 rsp_flag,
  output logic                 busy
);
  import alu_pkg::*;

  arb_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [IN_WIDTH-1:0]  in1_q, in1_d, in2_q, in2_d;
  logic [FUN_WIDTH-1:0] fun_q, fun_d;
  logic                 id_q, id_d;
  logic                 alu_en_q, alu_en_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [OUT_WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic                 rsp_flag_q, rsp_flag_d;
  logic                 busy_q, busy_d;
  logic [1:0]           grant;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Next-state, latch and capture logic; readys are only offered in IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    fun_d        = fun_q;
    id_d         = id_q;
    alu_en_d     = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_out_d    = rsp_out_q;
    rsp_flag_d   = rsp_flag_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (grant != 2'b00) begin
          in1_d        = grant[1] ? req1_in1 : req0_in1;
          in2_d        = grant[1] ? req1_in2 : req0_in2;
          fun_d        = grant[1] ? req1_fun : req0_fun;
          id_d         = grant[1] ? REQ_ID1 : REQ_ID0;
          last_grant_d = grant[1];
          alu_en_d     = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_id_d   = id_q;
        rsp_out_d  = alu_out;
        rsp_flag_d = alu_flag;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      in1_q        <= '0;
      in2_q        <= '0;
      fun_q        <= '0;
      id_q         <= 1'b0;
      alu_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_out_q    <= '0;
      rsp_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      fun_q        <= fun_d;
      id_q         <= id_d;
      alu_en_q     <= alu_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_flag_q   <= rsp_flag_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alu_fun   = fun_q;
  assign alu_en    = alu_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_flag  = rsp_flag_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a registered ALU model and a response scoreboard.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic        id;
    logic [15:0] out;
    logic        flag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_fun, req1_fun;
  logic [15:0] alu_in1, alu_in2;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out = 16'h0;
  logic        alu_flag = 1'b0;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
  logic [15:0] rsp_out;

  int   tests = 0;
  int   fails = 0;
  int   grants;
  int   n;
  rsp_t exp_q[$];

  alu_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_fun(req1_fun),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flag(rsp_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] f);
    case (f)
      FUN_AND: return a & b;
      FUN_OR:  return a | b;
      default: return a + b;
    endcase
  endfunction

  // Registered ALU model: one-cycle latency, flag = result nonzero.
  always @(posedge clk) begin
    if (alu_en) begin
      alu_out  <= alu_f(alu_in1, alu_in2, alu_fun);
      alu_flag <= (alu_f(alu_in1, alu_in2, alu_fun) != 16'h0);
    end
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted response must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_rsp: observed id %0d out %0h, expected no response",
               rsp_id, rsp_out);
      end
      if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        chk_b("rsp_id", rsp_id, e.id);
        chk_w("rsp_out", rsp_out, e.out);
        chk_b("rsp_flag", rsp_flag, e.flag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      tick();
      k++;
    end
    @(negedge clk);
    chk_w(tag, 16'(exp_q.size()), 16'd0);
    tick();
  endtask

  task automatic wait_rsp_valid(input string tag);
    int k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk_b(tag, rsp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_fun = '0;
    req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_fun = '0;
    repeat (2) tick();
    @(negedge clk);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_rsp_valid", rsp_valid, 1'b0);
    chk_b("rst_alu_en", alu_en, 1'b0);
    chk_w("rst_alu_in1", alu_in1, 16'h0);
    chk_w("rst_rsp_out", rsp_out, 16'h0);
    tick();
    rst = 1'b0;

    // Single op: AND 000B & 0009
    req0_valid = 1'b1; req0_in1 = 16'h000B; req0_in2 = 16'h0009; req0_fun = FUN_AND;
    exp_q.push_back('{id: 1'b0, out: 16'h0009, flag: 1'b1});
    @(negedge clk);
    chk_b("single_req0_ready", req0_ready, 1'b1);
    chk_b("single_req1_ready", req1_ready, 1'b0);
    chk_b("single_en_t0", alu_en, 1'b0);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk_b("single_en_t1", alu_en, 1'b1);
    chk_w("single_alu_in1", alu_in1, 16'h000B);
    chk_w("single_alu_fun", 16'(alu_fun), 16'h0004);
    chk_b("single_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk_b("single_en_t2", alu_en, 1'b0);
    chk_b("single_valid_t2", rsp_valid, 1'b0);
    chk_w("single_alu_in2", alu_in2, 16'h0009);
    tick();
    @(negedge clk);
    chk_b("single_valid_t3", rsp_valid, 1'b1);
    tick();
    @(negedge clk);
    chk_b("single_valid_t4", rsp_valid, 1'b0);
    chk_b("single_idle", busy, 1'b0);
    chk_w("single_hold_in1", alu_in1, 16'h000B);
    tick();

    // Tie from reset, then strict alternation over four ops
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_in1 = 16'h000B; req0_in2 = 16'h0009; req0_fun = FUN_OR;
    req1_valid = 1'b1; req1_in1 = 16'h00F0; req1_in2 = 16'h000F; req1_fun = FUN_AND;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{id: 1'b0, out: 16'h000B, flag: 1'b1});
      exp_q.push_back('{id: 1'b1, out: 16'h0000, flag: 1'b0});
    end
    grants = 0; n = 0;
    while (grants < 4 && n < 40) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk_b("tie_grant_order", req1_ready, 1'(grants % 2));
        grants++;
      end
      tick();
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk_w("tie_grant_count", 16'(grants), 16'd4);
    drain("tie_drain", 40);

    // Backpressure: response stalls while req1 waits
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_in1 = 16'h00F0; req0_in2 = 16'h000F; req0_fun = FUN_OR;
    exp_q.push_back('{id: 1'b0, out: 16'h00FF, flag: 1'b1});
    @(negedge clk);
    chk_b("bp_req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_in1 = 16'h0F0F; req1_in2 = 16'h00FF; req1_fun = FUN_AND;
    exp_q.push_back('{id: 1'b1, out: 16'h000F, flag: 1'b1});
    wait_rsp_valid("bp_rsp_valid");
    for (int i = 0; i < 10; i++) begin
      chk_b("bp_stall_valid", rsp_valid, 1'b1);
      chk_b("bp_stall_id", rsp_id, 1'b0);
      chk_w("bp_stall_out", rsp_out, 16'h00FF);
      chk_b("bp_stall_flag", rsp_flag, 1'b1);
      chk_b("bp_stall_req1_ready", req1_ready, 1'b0);
      chk_b("bp_stall_busy", busy, 1'b1);
      @(negedge clk);
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    chk_b("bp_release_req1_ready", req1_ready, 1'b0);
    tick();
    @(negedge clk);
    chk_b("bp_after_valid", rsp_valid, 1'b0);
    chk_b("bp_req1_granted", req1_ready, 1'b1);
    tick(); req1_valid = 1'b0;
    drain("bp_drain", 10);

    // Reset during WAIT discards the operation
    req0_valid = 1'b1; req0_in1 = 16'h1111; req0_in2 = 16'h2222; req0_fun = FUN_OR;
    @(negedge clk);
    chk_b("rmo_req0_ready", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0;
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    chk_b("rmo_busy", busy, 1'b0);
    chk_b("rmo_rsp_valid", rsp_valid, 1'b0);
    chk_b("rmo_alu_en", alu_en, 1'b0);
    chk_w("rmo_alu_in1", alu_in1, 16'h0);
    chk_w("rmo_alu_in2", alu_in2, 16'h0);
    chk_w("rmo_alu_fun", 16'(alu_fun), 16'h0);
    chk_w("rmo_rsp_out", rsp_out, 16'h0);
    chk_b("rmo_rsp_id", rsp_id, 1'b0);
    chk_b("rmo_rsp_flag", rsp_flag, 1'b0);
    chk_b("rmo_req0_ready_off", req0_ready, 1'b0);
    tick(); rst = 1'b0;
    repeat (6) tick();
    req1_valid = 1'b1; req1_in1 = 16'h1234; req1_in2 = 16'h00FF; req1_fun = FUN_AND;
    exp_q.push_back('{id: 1'b1, out: 16'h0034, flag: 1'b1});
    @(negedge clk);
    chk_b("rmo_next_req1_ready", req1_ready, 1'b1);
    tick(); req1_valid = 1'b0;
    drain("rmo_drain", 10);

    // Valid withdrawal by req1 while req0's response is pending
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_in1 = 16'h0000; req0_in2 = 16'h0000; req0_fun = FUN_OR;
    exp_q.push_back('{id: 1'b0, out: 16'h0000, flag: 1'b0});
    @(negedge clk);
    chk_b("wd_req0_ready", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0;
    wait_rsp_valid("wd_rsp_valid");
    tick();
    req1_valid = 1'b1; req1_in1 = 16'h5555; req1_in2 = 16'hAAAA; req1_fun = FUN_AND;
    @(negedge clk);
    chk_b("wd_req1_ready", req1_ready, 1'b0);
    tick(); req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk_b("wd_idle", busy, 1'b0);
    chk_w("final_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one registered 16-bit ALU (arithmetic/logic/shift/compare units, one-cycle result latency) between two requesters.
- Arbitrates round-robin, sequences the operation (latch, issue enable, capture), and returns the result with requester ID over a valid/ready response channel.
- Sits between the CPU-side command sources and the ALU top.

Parameters:
- IN_WIDTH, 16, width of each operand.
- OUT_WIDTH, 16, width of the ALU result and response data.
- FUN_WIDTH, 4, width of the ALU function code. The code is passed through opaquely.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_in1  in  IN_WIDTH  requester 0 operand 1.
- req0_in2  in  IN_WIDTH  requester 0 operand 2.
- req0_fun  in  FUN_WIDTH  requester 0 function code.
- req1_valid, req1_ready, req1_in1, req1_in2, req1_fun: same as requester 0, for requester 1.
- alu_in1  out  IN_WIDTH  operand 1 to the ALU.
- alu_in2  out  IN_WIDTH  operand 2 to the ALU.
- alu_fun  out  FUN_WIDTH  function code to the ALU.
- alu_en  out  1  ALU enable; the ALU registers its result on the edge ending an enabled cycle.
- alu_out  in  OUT_WIDTH  registered ALU result.
- alu_flag  in  1  registered ALU flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  ID of the requester that issued the operation.
- rsp_out  out  OUT_WIDTH  captured result.
- rsp_flag  out  1  captured flag.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: state=IDLE, last_grant=1 (req0 wins the first tie), and all of the following are 0: operand/fun/ID registers, alu_en, alu_in1, alu_in2, alu_fun, rsp_valid, rsp_id, rsp_out, rsp_flag, busy, req0_ready, req1_ready.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. Requesters must re-present the command.
- FSM has four states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If neither valid is high, stay in IDLE; both readys are 0.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready is combinational: high only for the granted requester, only in IDLE.
  - On the handshake: latch in1, in2, fun and ID; update last_grant; go to ISSUE.
- ISSUE:
  - alu_en=1 for exactly one cycle.
  - alu_in1, alu_in2 and alu_fun are driven from the latched registers; go to WAIT.
- WAIT:
  - alu_en=0; the latched operands stay driven.
  - At the end of the cycle, capture alu_out and alu_flag into the response registers; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_out and rsp_flag are held stable until rsp_ready.
  - When rsp_valid && rsp_ready, go to IDLE. rsp_valid drops in the next cycle.
  - New requests are not accepted in RESP; both readys are 0.
- alu_in1, alu_in2 and alu_fun hold their last latched values in IDLE and RESP (no glitching to 0).
- Latency: handshake at cycle t -> alu_en at t+1 -> rsp_valid first high at t+3. Minimum of 4 cycles per operation.
- Requester protocol: valid and command fields must remain stable until ready. Ready may depend combinationally on valid; valid must not depend on ready.
- rsp_ready held low: the block stalls in RESP indefinitely. No data is lost, and no new grant is made.
- A requester may drop valid without a grant; nothing is latched for it.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1.
- No width conversion: OUT_WIDTH result bits are passed through unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - FUN_WIDTH and the function-code localparams used by the ALU top and bench;
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - requester ID constants.
- One sub-module: rr_arb2. It is a combinational 2-way round-robin grant that takes the valids and last_grant and outputs a one-hot grant. The FSM stays in alu_req_arbiter.

Test Plan:
- Bench ALU model: registered, 1-cycle latency; fun 4'h4 = AND, 4'h5 = OR; flag is set when the result is nonzero.
- Single op: req0 presents in1=16'h000B, in2=16'h0009, fun=AND; rsp_ready=1 -> req0_ready=1 in the handshake cycle, alu_en pulses once at t+1, and at t+3 rsp_valid=1, rsp_id=0, rsp_out=16'h0009, rsp_flag=1.
- Tie and fairness: both valid from reset, req0 OR 16'h000B|16'h0009 and req1 AND 16'h00F0&16'h000F -> req0 is served first (rsp 16'h000B, id 0), then req1 (rsp 16'h0000, id 1, flag 0). Keep both valid for 4 ops -> IDs 0,1,0,1.
- Backpressure: hold rsp_ready=0 for 10 cycles with req1 valid -> rsp fields stable, req1_ready stays 0, busy=1. Raise rsp_ready -> IDLE next cycle, then req1 is granted.
- Reset mid-op: assert rst during WAIT -> next cycle all outputs are 0 and state is IDLE. No rsp_valid for the discarded op; the next request completes normally.
- Valid withdrawal: req1 pulses valid for one cycle while the block is in RESP for req0 -> no req1 grant occurs and no response with id 1 is produced.
